digitallock_multi_timer: RTL and testbench

Parametrised N-channel down-counting interval timer on a 32-bit Avalon-MM slave, successor to the single-channel 16-bit-bus system timer. Each channel has its own period, one-shot/continuous mode, sticky timeout flag and interrupt enable. An optional per-channel prescaler divides the count rate. It sits on the Nios II data bus beside the existing peripherals and drives one combined IRQ line plus a per-channel IRQ vector.

---
 rtl/digitallock_multi_timer.sv | 246 ++++++++++++++++++++++++
 tb/tb_digitallock_multi_timer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digitallock_multi_timer.sv
// -----------------------------------------------------------------------------
// digitallock_multi_timer
//
// N-channel down-counting interval timer on a 32-bit Avalon-MM slave.
// Each channel has a period, a live counter, one-shot/continuous mode, a
// sticky timeout flag (TO) and an interrupt enable (ITO).
//
// Optional feature: define DIGITALLOCK_TIMER_PRESCALE_EN to give every channel
// an 8-bit prescaler (CONTROL[15:8] = PRE, tick rate clk/(PRE+1)). Without the
// macro the channels tick every cycle and no prescaler flops exist.
//
// Register map, word address = {channel, reg[1:0]}:
//   0 STATUS  : bit0 TO (sticky), bit1 RUN. Any write clears TO.
//   1 CONTROL : bit0 ITO, bit1 CONT, bit2 START (strobe), bit3 STOP (strobe),
//               bits[15:8] PRE (prescaler build only).
//   2 PERIOD  : CNT_W bits. A write reloads COUNT and stops the channel.
//   3 COUNT   : live counter, read-only.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   address    in   AW-bit word address {ch, reg}
//   chipselect in   slave select
//   write_n    in   active-low write strobe (write = chipselect && !write_n)
//   writedata  in   32-bit write data
//   readdata   out  registered read data, 1-cycle latency, 0 when not reading
//   irq        out  OR of irq_vec
//   irq_vec    out  per-channel TO && ITO
// -----------------------------------------------------------------------------
module digitallock_multi_timer #(
  parameter int  N_CH         = 2,
  parameter int  CNT_W        = 32,
  parameter int  RESET_PERIOD = 49999,
  localparam int AW           = $clog2(N_CH) + 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   address,
  input  logic            chipselect,
  input  logic            write_n,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic            irq,
  output logic [N_CH-1:0] irq_vec
);

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_COUNT   = 2'd3
  } reg_e;

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count_q  [N_CH];
  logic [CNT_W-1:0] count_d  [N_CH];
  logic [CNT_W-1:0] period_q [N_CH];
  logic [CNT_W-1:0] period_d [N_CH];
  logic [N_CH-1:0]  run_q, run_d;
  logic [N_CH-1:0]  to_q, to_d;
  logic [N_CH-1:0]  ito_q, ito_d;
  logic [N_CH-1:0]  cont_q, cont_d;
  logic [31:0]      readdata_q, readdata_d;
`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
  logic [7:0]       pre_q [N_CH];
  logic [7:0]       pre_d [N_CH];
  logic [7:0]       psc_q [N_CH];
  logic [7:0]       psc_d [N_CH];
`endif

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic            wr_en;
  logic            rd_en;
  reg_e            reg_sel;
  logic [AW-1:0]   ch_sel;
  logic [N_CH-1:0] wr_ch;
  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] to_evt;
  logic            unused_wdata;

  assign wr_en   = chipselect && !write_n;
  assign rd_en   = chipselect && write_n;
  assign reg_sel = reg_e'(address[1:0]);
  assign ch_sel  = address >> 2;

  // Upper writedata bits have no destination in every configuration.
  assign unused_wdata = ^writedata;

  // Only channels below N_CH are ever matched, so an out-of-range channel
  // index decodes to nothing: writes are dropped and reads return 0.
  // NOTE: every signal driven in always_comb gets a default before any
  // conditional assignment; otherwise synthesis infers a latch.
  always_comb begin
    wr_ch = '0;
    for (int c = 0; c < N_CH; c++) begin
      wr_ch[c] = wr_en && (ch_sel == AW'(c));
    end
  end

`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
  always_comb begin
    tick = '0;
    for (int c = 0; c < N_CH; c++) begin
      tick[c] = (psc_q[c] == pre_q[c]);
    end
  end
`else
  assign tick = '1;
`endif

  // A timeout fires on a tick while running with the counter at zero.
  always_comb begin
    to_evt = '0;
    for (int c = 0; c < N_CH; c++) begin
      to_evt[c] = run_q[c] && tick[c] && (count_q[c] == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Order inside the loop encodes the priorities:
  // counting first, then register writes override it (START last among the
  // RUN updates so it beats STOP), and a timeout set beats a STATUS clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    run_d    = run_q;
    to_d     = to_q;
    ito_d    = ito_q;
    cont_d   = cont_q;
`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
    pre_d    = pre_q;
    psc_d    = psc_q;
`endif

    for (int c = 0; c < N_CH; c++) begin
      if (run_q[c] && tick[c]) begin
        if (count_q[c] == '0) begin
          count_d[c] = period_q[c];
          if (!cont_q[c]) run_d[c] = 1'b0;
        end else begin
          count_d[c] = count_q[c] - CNT_W'(1);
        end
      end

`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
      if (run_q[c]) psc_d[c] = tick[c] ? 8'd0 : psc_q[c] + 8'd1;
`endif

      if (wr_ch[c] && reg_sel == REG_STATUS) to_d[c] = 1'b0;
      if (to_evt[c])                         to_d[c] = 1'b1;

      if (wr_ch[c] && reg_sel == REG_CONTROL) begin
        ito_d[c]  = writedata[0];
        cont_d[c] = writedata[1];
`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
        pre_d[c]  = writedata[15:8];
`endif
        if (writedata[3]) run_d[c] = 1'b0;
        if (writedata[2]) begin
          run_d[c] = 1'b1;
`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
          psc_d[c] = 8'd0;
`endif
        end
      end

      if (wr_ch[c] && reg_sel == REG_PERIOD) begin
        period_d[c] = writedata[CNT_W-1:0];
        count_d[c]  = writedata[CNT_W-1:0];
        run_d[c]    = 1'b0;
`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
        psc_d[c]    = 8'd0;
`endif
      end
    end
  end

  // Read mux: data is captured every cycle and is 0 when no read is issued.
  always_comb begin
    readdata_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rd_en && ch_sel == AW'(c)) begin
        unique case (reg_sel)
          REG_STATUS:  readdata_d = {30'd0, run_q[c], to_q[c]};
`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
          REG_CONTROL: readdata_d = {16'd0, pre_q[c], 6'd0, cont_q[c], ito_q[c]};
`else
          REG_CONTROL: readdata_d = {30'd0, cont_q[c], ito_q[c]};
`endif
          REG_PERIOD:  readdata_d = 32'(period_q[c]);
          REG_COUNT:   readdata_d = 32'(count_q[c]);
          default:     readdata_d = '0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-channel arrays are architectural registers with defined
      // reset values, so they are reset explicitly (they are not RAM).
      for (int c = 0; c < N_CH; c++) begin
        count_q[c]  <= RST_VAL;
        period_q[c] <= RST_VAL;
`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
        pre_q[c]    <= 8'd0;
        psc_q[c]    <= 8'd0;
`endif
      end
      run_q      <= '0;
      to_q       <= '0;
      ito_q      <= '0;
      cont_q     <= '0;
      readdata_q <= '0;
    end else begin
      count_q    <= count_d;
      period_q   <= period_d;
`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
      pre_q      <= pre_d;
      psc_q      <= psc_d;
`endif
      run_q      <= run_d;
      to_q       <= to_d;
      ito_q      <= ito_d;
      cont_q     <= cont_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_vec  = to_q & ito_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_digitallock_multi_timer.sv
// -----------------------------------------------------------------------------
// Testbench for digitallock_multi_timer.
// dut_a: default build (N_CH=2, CNT_W=32).
// dut_b: N_CH=3, CNT_W=16, so channel index 3 is an unmapped address.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every bus task starts and ends on a falling edge and takes exactly one cycle.
// -----------------------------------------------------------------------------
module tb_digitallock_multi_timer;

  localparam logic [31:0] RST_P = 32'd49999;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  addr;
  logic        cs_a, cs_b, wn;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;
  logic [1:0]  irqv_a;
  logic [2:0]  irqv_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  digitallock_multi_timer dut_a (
    .clk        (clk),
    .reset      (reset),
    .address    (addr[2:0]),
    .chipselect (cs_a),
    .write_n    (wn),
    .writedata  (wdata),
    .readdata   (rdata_a),
    .irq        (irq_a),
    .irq_vec    (irqv_a)
  );

  digitallock_multi_timer #(.N_CH(3), .CNT_W(16)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .address    (addr),
    .chipselect (cs_b),
    .write_n    (wn),
    .writedata  (wdata),
    .readdata   (rdata_b),
    .irq        (irq_b),
    .irq_vec    (irqv_b)
  );

  // Single-cycle bus write; d selects dut_b.
  task automatic wr(input bit d, input logic [3:0] a, input logic [31:0] data);
    addr = a; wdata = data; wn = 1'b0; cs_a = !d; cs_b = d;
    @(negedge clk);
    cs_a = 1'b0; cs_b = 1'b0; wn = 1'b1;
  endtask

  // Single-cycle bus read; result is the registered readdata one cycle later.
  task automatic rd(input bit d, input logic [3:0] a, output logic [31:0] data);
    addr = a; wn = 1'b1; cs_a = !d; cs_b = d;
    @(negedge clk);
    cs_a = 1'b0; cs_b = 1'b0;
    data = d ? rdata_b : rdata_a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++; if (rdata_a !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata_a); end
    checks++; if (irq_a !== 1'b0 || irqv_a !== 2'b00) begin errors++; $display("FAIL reset_irq got %b/%b exp 0/00", irq_a, irqv_a); end
    rd(0, 4'd0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_status got %h exp 0", v); end
    rd(0, 4'd1, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_control got %h exp 0", v); end
    rd(0, 4'd6, v);
    checks++; if (v !== RST_P) begin errors++; $display("FAIL reset_period1 got %0d exp %0d", v, RST_P); end
    rd(1, 4'd11, v);
    checks++; if (v !== RST_P) begin errors++; $display("FAIL reset_count_b2 got %0d exp %0d", v, RST_P); end
  endtask

  // ch0 PERIOD=3, START|CONT|ITO, then COUNT read back-to-back every cycle.
  task automatic test_continuous;
    logic [31:0] exp_cnt [8];
    exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
    wr(0, 4'd2, 32'd3);
    wr(0, 4'd1, 32'h7);
    addr = 4'd3; wn = 1'b1; cs_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (rdata_a !== exp_cnt[k]) begin errors++; $display("FAIL cont_count[%0d] got %0d exp %0d", k, rdata_a, exp_cnt[k]); end
      checks++; if (irq_a !== (k >= 3)) begin errors++; $display("FAIL cont_irq[%0d] got %b exp %b", k, irq_a, (k >= 3)); end
    end
    cs_a = 1'b0;
    rd(0, 4'd0, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL cont_status got %h exp 3", v); end
  endtask

  // STATUS write on the exact timeout edge keeps TO; a later one clears it.
  task automatic test_collision;
    wr(0, 4'd2, 32'd3);
    wr(0, 4'd1, 32'h7);
    wr(0, 4'd0, 32'd0);
    checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL coll_clear got %b exp 0", irq_a); end
    idle(2);
    wr(0, 4'd0, 32'd0);
    checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL coll_keep got %b exp 1", irq_a); end
    wr(0, 4'd0, 32'd0);
    checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL coll_later_clear got %b exp 0", irq_a); end
    wr(0, 4'd1, 32'h8);
    wr(0, 4'd0, 32'd0);
    rd(0, 4'd0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL coll_stopped got %h exp 0", v); end
  endtask

  // ch1 PERIOD=5 one-shot: timeout on the 6th tick, RUN drops, COUNT reloads.
  task automatic test_one_shot;
    wr(0, 4'd6, 32'd5);
    wr(0, 4'd5, 32'h4);
    idle(5);
    rd(0, 4'd4, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL oneshot_pre got %h exp 2", v); end
    rd(0, 4'd4, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL oneshot_done got %h exp 1", v); end
    rd(0, 4'd7, v);
    checks++; if (v !== 32'd5) begin errors++; $display("FAIL oneshot_count got %0d exp 5", v); end
    checks++; if (irq_a !== 1'b0 || irqv_a !== 2'b00) begin errors++; $display("FAIL oneshot_irq got %b/%b exp 0/00", irq_a, irqv_a); end
  endtask

  // ITO gates irq_vec without touching the sticky TO.
  task automatic test_ito;
    wr(0, 4'd5, 32'h1);
    checks++; if (irqv_a !== 2'b10 || irq_a !== 1'b1) begin errors++; $display("FAIL ito_on got %b/%b exp 10/1", irqv_a, irq_a); end
    wr(0, 4'd5, 32'h0);
    checks++; if (irqv_a !== 2'b00 || irq_a !== 1'b0) begin errors++; $display("FAIL ito_off got %b/%b exp 00/0", irqv_a, irq_a); end
    rd(0, 4'd4, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL ito_to_kept got %h exp 1", v); end
`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
    wr(0, 4'd5, 32'h0000_0500);
    rd(0, 4'd5, v);
    checks++; if (v !== 32'h0000_0500) begin errors++; $display("FAIL ctrl_pre_read got %h exp 500", v); end
`else
    wr(0, 4'd5, 32'h0000_FF02);
    rd(0, 4'd5, v);
    checks++; if (v !== 32'h0000_0002) begin errors++; $display("FAIL ctrl_read got %h exp 2", v); end
`endif
    wr(0, 4'd5, 32'h0);
  endtask

  // START and STOP together: START wins. STOP alone clears RUN.
  task automatic test_start_stop;
    wr(0, 4'd5, 32'hC);
    rd(0, 4'd4, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL startstop_run got %h exp 3", v); end
    wr(0, 4'd5, 32'h8);
    rd(0, 4'd4, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL stop_run got %h exp 1", v); end
  endtask

  // PERIOD write mid-count stops the channel and loads COUNT.
  task automatic test_period_write;
    wr(0, 4'd6, 32'd20);
    wr(0, 4'd5, 32'h6);
    idle(3);
    wr(0, 4'd6, 32'd9);
    rd(0, 4'd7, v);
    checks++; if (v !== 32'd9) begin errors++; $display("FAIL pwr_count got %0d exp 9", v); end
    rd(0, 4'd4, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL pwr_status got %h exp 1", v); end
    rd(0, 4'd6, v);
    checks++; if (v !== 32'd9) begin errors++; $display("FAIL pwr_period got %0d exp 9", v); end
  endtask

`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
  // PRE=1, PERIOD=2: first timeout 6 clocks after START.
  task automatic test_prescale;
    wr(0, 4'd0, 32'd0);
    wr(0, 4'd2, 32'd2);
    wr(0, 4'd1, 32'h107);
    for (int k = 0; k < 6; k++) begin
      checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL psc_early[%0d] got %b exp 0", k, irq_a); end
      @(negedge clk);
    end
    checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL psc_timeout got %b exp 1", irq_a); end
    rd(0, 4'd1, v);
    checks++; if (v !== 32'h103) begin errors++; $display("FAIL psc_ctrl got %h exp 103", v); end
    wr(0, 4'd2, 32'd9);
    rd(0, 4'd3, v);
    checks++; if (v !== 32'd9) begin errors++; $display("FAIL psc_pwr_count got %0d exp 9", v); end
    rd(0, 4'd0, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL psc_pwr_status got %h exp 1", v); end
    wr(0, 4'd1, 32'h0);
    wr(0, 4'd0, 32'd0);
  endtask
`endif

  // dut_b: ch1 PERIOD=0xFFFF, ch2 PERIOD=2, both continuous with ITO.
  task automatic test_multi;
    wr(1, 4'd6, 32'h0000_FFFF);
    wr(1, 4'd10, 32'd2);
    wr(1, 4'd5, 32'h7);
    wr(1, 4'd9, 32'h7);
    for (int k = 0; k < 3; k++) begin
      checks++; if (irqv_b !== 3'b000) begin errors++; $display("FAIL multi_early[%0d] got %b exp 000", k, irqv_b); end
      @(negedge clk);
    end
    checks++; if (irqv_b !== 3'b100 || irq_b !== 1'b1) begin errors++; $display("FAIL multi_to1 got %b/%b exp 100/1", irqv_b, irq_b); end
    rd(1, 4'd7, v);
    checks++; if (v !== 32'h0000_FFFB) begin errors++; $display("FAIL multi_ch1_count got %h exp fffb", v); end
    wr(1, 4'd8, 32'd0);
    checks++; if (irqv_b !== 3'b000 || irq_b !== 1'b0) begin errors++; $display("FAIL multi_clear got %b/%b exp 000/0", irqv_b, irq_b); end
    @(negedge clk);
    checks++; if (irqv_b !== 3'b100) begin errors++; $display("FAIL multi_to2 got %b exp 100", irqv_b); end
  endtask

  // dut_b channel index 3 is unmapped.
  task automatic test_invalid_ch;
    wr(1, 4'd14, 32'h0000_0055);
    wr(1, 4'd13, 32'h7);
    wr(1, 4'd12, 32'd0);
    rd(1, 4'd14, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL inv_period got %h exp 0", v); end
    rd(1, 4'd15, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL inv_count got %h exp 0", v); end
    rd(1, 4'd2, v);
    checks++; if (v !== RST_P) begin errors++; $display("FAIL inv_alias_ch0 got %0d exp %0d", v, RST_P); end
    rd(1, 4'd0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL inv_ch0_status got %h exp 0", v); end
  endtask

  // Reset while ch0 is counting with TO/irq set.
  task automatic test_reset_midcount;
    wr(0, 4'd2, 32'd3);
    wr(0, 4'd1, 32'h7);
    idle(4);
    checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL rstmid_pre_irq got %b exp 1", irq_a); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (irq_a !== 1'b0 || rdata_a !== 32'd0) begin errors++; $display("FAIL rstmid_out got irq %b rd %h exp 0/0", irq_a, rdata_a); end
    rd(0, 4'd0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rstmid_status got %h exp 0", v); end
    rd(0, 4'd3, v);
    checks++; if (v !== RST_P) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", v, RST_P); end
    rd(0, 4'd2, v);
    checks++; if (v !== RST_P) begin errors++; $display("FAIL rstmid_period got %0d exp %0d", v, RST_P); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr = '0; cs_a = 1'b0; cs_b = 1'b0; wn = 1'b1; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_continuous();
    test_collision();
    test_one_shot();
    test_ito();
    test_start_stop();
    test_period_write();
`ifdef DIGITALLOCK_TIMER_PRESCALE_EN
    test_prescale();
`endif
    test_multi();
    test_invalid_ch();
    test_reset_midcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
